// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and FSM encoding for the direct-mapped data cache
package cache_pkg;
  localparam int TAG_W = 3;
  localparam int INDEX_W = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W = 32;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
endpackage

// File: rtl/cache_fsm.sv
// cache_fsm: miss-handling state machine and memory-side outputs
module cache_fsm
  import cache_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       miss,
  input  logic                       victim_dirty,
  input  logic                       MEM_BUSYWAIT,
  input  logic [TAG_W+INDEX_W-1:0]   blk_addr,
  input  logic [TAG_W-1:0]           victim_tag,
  input  logic [BLOCK_W-1:0]         victim_data,
  output state_t                     state,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [TAG_W+INDEX_W-1:0]   MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA
);
  state_t state_n;
  always_comb begin
    state_n = state == IDLE      ? (miss ? (victim_dirty ? WRITEBACK : FETCH) : IDLE)
            : state == WRITEBACK ? (MEM_BUSYWAIT ? WRITEBACK : FETCH)
            : state == FETCH     ? (MEM_BUSYWAIT ? FETCH : UPDATE)
            : IDLE;
    MEM_READ = state == FETCH;
    MEM_WRITE = state == WRITEBACK;
    MEM_ADDRESS = state == WRITEBACK ? {victim_tag, blk_addr[INDEX_W-1:0]} : blk_addr;
    MEM_WRITEDATA = victim_data;
  end
  always_ff @(posedge CLK)
    state <= RESET ? IDLE : state_n;
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back byte cache between CPU and block memory
module data_cache
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [7:0]                 ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [TAG_W+INDEX_W-1:0]   MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
);
  logic [BLOCK_BYTES*8-1:0] lines [NUM_BLOCKS];
  logic [TAG_W-1:0] tags [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid, dirty;
  logic [BLOCK_W-1:0] fill;
  logic [TAG_W-1:0] tag;
  logic [INDEX_W-1:0] idx;
  logic [OFFSET_W-1:0] off;
  logic hit, idle;
  state_t state;
  always_comb begin
    tag = ADDRESS[7:5];
    idx = ADDRESS[4:2];
    off = ADDRESS[1:0];
    hit = valid[idx] && tags[idx] == tag;
    idle = state == IDLE;
    BUSYWAIT = (READ || WRITE) && !(idle && hit);
    READDATA = (READ && !WRITE && idle && hit) ? lines[idx][{off, 3'b000} +: 8] : 8'h00;
  end
  cache_fsm u_fsm (
    .CLK(CLK), .RESET(RESET),
    .miss((READ || WRITE) && !hit),
    .victim_dirty(valid[idx] && dirty[idx]),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .blk_addr(ADDRESS[7:2]),
    .victim_tag(tags[idx]),
    .victim_data(lines[idx]),
    .state(state),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA)
  );
  always_ff @(posedge CLK)
    if (state == FETCH && !MEM_BUSYWAIT) fill <= MEM_READDATA;
  // line data and tags survive reset; only valid/dirty are cleared
  always_ff @(posedge CLK)
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == UPDATE) begin
      lines[idx] <= fill;
      tags[idx] <= tag;
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (idle && hit && WRITE) begin
      lines[idx][{off, 3'b000} +: 8] <= WRITEDATA;
      dirty[idx] <= 1'b1;
    end
endmodule
